// File: rtl/cu_gen2_pkg.sv
// cu_gen2_pkg
// Shared definitions for the PATP control unit:
//  - opcode values and the first illegal opcode
//  - ALU function codes driven on func
//  - FSM phase encoding and trap cause codes
//  - isWaitStep(): tells whether a phase/step/opcode combination is a memory
//    wait step, where the FSM holds until mem_ready or the timeout fires
package cu_gen2_pkg;

  localparam int unsigned OP_CLEAR         = 0;
  localparam int unsigned OP_INC1          = 1;
  localparam int unsigned OP_ADD           = 2;
  localparam int unsigned OP_DEC1          = 3;
  localparam int unsigned OP_JUMP          = 4;
  localparam int unsigned OP_BUZ           = 5;
  localparam int unsigned OP_LOAD          = 6;
  localparam int unsigned OP_STORE         = 7;
  localparam int unsigned OP_NOP           = 8;
  localparam int unsigned OP_HALT          = 9;
  localparam int unsigned OP_FIRST_ILLEGAL = 10;

  typedef enum logic [1:0] {
    FUNC_CLR = 2'd0,
    FUNC_INC = 2'd1,
    FUNC_DEC = 2'd2,
    FUNC_ADD = 2'd3
  } func_e;

  typedef enum logic [1:0] {
    PH_FETCH = 2'd0,
    PH_EXEC  = 2'd1,
    PH_HALT  = 2'd2,
    PH_TRAP  = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_TIMEOUT = 2'd2
  } cause_e;

  // Micro-step number; only 1..5 are ever used.
  typedef logic [2:0] step_t;

  // Memory wait steps: F2 (instruction read), ADD E4 (operand read),
  // LOAD E2 (read) and STORE E2 (write).
  function automatic logic isWaitStep(input phase_e ph, input step_t st,
                                      input logic [31:0] op);
    logic fetchWait;
    logic execWait;
    fetchWait = (ph == PH_FETCH) && (st == 3'd2);
    execWait  = (ph == PH_EXEC) &&
                (((op == OP_ADD) && (st == 3'd4)) ||
                 (((op == OP_LOAD) || (op == OP_STORE)) && (st == 3'd2)));
    return fetchWait || execWait;
  endfunction

endpackage

// File: rtl/cu_gen2_if.sv
// cu_gen2_if
// Bundle of every signal between the control unit and the rest of the core.
//  Inputs to the CU : opcode, reg_sel, zero, mem_ready, run
//  Outputs from CU  : oe_ms, oe_ir, oe_pc, oe_alureg, oe_d   bus output enables
//                     func                                  ALU operation
//                     read, write                           memory strobes
//                     we_mar, we_ir, we_pc, we_alureg, we_d write enables
//                     fetching, halted, trap, trap_cause    status
// Modports: master = control unit side, slave = datapath/memory side.
interface cu_gen2_if #(
  parameter int OPCODE_W  = 4,
  parameter int NUM_DREGS = 4,
  parameter int REG_SEL_W = $clog2(NUM_DREGS)
);

  logic [OPCODE_W-1:0]  opcode;
  logic [REG_SEL_W-1:0] reg_sel;
  logic                 zero;
  logic                 mem_ready;
  logic                 run;

  logic                 oe_ms;
  logic                 oe_ir;
  logic                 oe_pc;
  logic                 oe_alureg;
  logic [NUM_DREGS-1:0] oe_d;
  logic [1:0]           func;
  logic                 read;
  logic                 write;
  logic                 we_mar;
  logic                 we_ir;
  logic                 we_pc;
  logic                 we_alureg;
  logic [NUM_DREGS-1:0] we_d;
  logic                 fetching;
  logic                 halted;
  logic                 trap;
  logic [1:0]           trap_cause;

  modport master (
    input  opcode, reg_sel, zero, mem_ready, run,
    output oe_ms, oe_ir, oe_pc, oe_alureg, oe_d, func, read, write,
           we_mar, we_ir, we_pc, we_alureg, we_d,
           fetching, halted, trap, trap_cause
  );

  modport slave (
    output opcode, reg_sel, zero, mem_ready, run,
    input  oe_ms, oe_ir, oe_pc, oe_alureg, oe_d, func, read, write,
           we_mar, we_ir, we_pc, we_alureg, we_d,
           fetching, halted, trap, trap_cause
  );

endinterface

// File: rtl/cu_gen2_mem_wait_timer.sv
// mem_wait_timer
// Counts cycles spent waiting for mem_ready on one memory access.
//  clk       clock
//  rst       synchronous reset, active-low
//  clear_i   forces the count back to zero (asserted whenever not waiting)
//  enable_i  counts one more cycle without mem_ready
//  expire_o  this cycle is the MEM_TIMEOUT-th cycle without mem_ready; the
//            access must be abandoned at the coming edge
// MEM_TIMEOUT = 0 disables the timeout entirely.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins over counting so every new wait step starts
  // from zero even if the previous step ended without mem_ready.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expiry fires on the cycle whose missing mem_ready would push the count
  // to MEM_TIMEOUT, so the strobe is seen for exactly MEM_TIMEOUT cycles.
  generate
    if (MEM_TIMEOUT == 0) begin : gNoTimeout
      assign expire_o = 1'b0;
    end else begin : gTimeout
      assign expire_o = enable_i && (count_q == CNT_W'(MEM_TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/cu_gen2.sv
// cu_gen2
// Control unit for the PATP core. Sequences fetch (F1..F4) and execute
// (E1..E5) micro-steps and decodes datapath enables from the current step.
//  clk   clock, all state changes on the rising edge
//  rst   synchronous reset, active-low; returns to F1 immediately
//  bus   cu_gen2_if master: IR fields, flags and mem_ready in; bus/write
//        enables, ALU func, memory strobes and status out
// Adds N data registers, memory wait states with timeout, HALT/resume and
// an illegal-opcode trap. TRAP is left only through reset.
module cu_gen2 #(
  parameter int OPCODE_W    = 4,
  parameter int NUM_DREGS   = 4,
  parameter int REG_SEL_W   = $clog2(NUM_DREGS),
  parameter int MEM_TIMEOUT = 16
) (
  input logic       clk,
  input logic       rst,
  cu_gen2_if.master bus
);

  import cu_gen2_pkg::*;

  phase_e phase_q;
  phase_e phase_d;
  step_t  step_q;
  step_t  step_d;
  cause_e cause_q;
  cause_e cause_d;

  logic [OPCODE_W-1:0]  opcodeRaw;
  logic [REG_SEL_W-1:0] regSelRaw;
  logic [31:0]          op;
  logic [NUM_DREGS-1:0] dSel;
  logic                 waiting;
  logic                 expire;

  logic                 oeMs;
  logic                 oeIr;
  logic                 oePc;
  logic                 oeAlu;
  logic [NUM_DREGS-1:0] oeD;
  func_e                func;
  logic                 rdStrobe;
  logic                 wrStrobe;
  logic                 weMar;
  logic                 weIr;
  logic                 wePc;
  logic                 weAlu;
  logic [NUM_DREGS-1:0] weD;

  assign opcodeRaw = bus.opcode;
  assign regSelRaw = bus.reg_sel;
  assign op        = 32'(opcodeRaw);

  // One-hot data register select. A reg_sel that names no register leaves
  // every bit clear, which silently disables oe_d/we_d for that instruction.
  always_comb begin
    dSel = '0;
    for (int i = 0; i < NUM_DREGS; i++) begin
      if (int'(regSelRaw) == i) begin
        dSel[i] = 1'b1;
      end
    end
  end

  assign waiting = isWaitStep(phase_q, step_q, op);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) uWaitTimer (
    .clk     (clk),
    .rst     (rst),
    .clear_i (!waiting),
    .enable_i(waiting && !bus.mem_ready),
    .expire_o(expire)
  );

  // State register: phase, micro-step and the latched trap cause.
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q <= PH_FETCH;
      step_q  <= 3'd1;
      cause_q <= CAUSE_NONE;
    end else begin
      phase_q <= phase_d;
      step_q  <= step_d;
      cause_q <= cause_d;
    end
  end

  // Next-state logic. Wait steps hold until mem_ready; a timeout in any
  // wait step abandons the instruction and traps. Any step number an
  // opcode does not use falls back to F1 so the FSM cannot wedge.
  always_comb begin
    phase_d = phase_q;
    step_d  = step_q;
    cause_d = cause_q;
    unique case (phase_q)
      PH_FETCH: begin
        case (step_q)
          3'd1: step_d = 3'd2;
          3'd2: begin
            if (bus.mem_ready) begin
              step_d = 3'd3;
            end else if (expire) begin
              phase_d = PH_TRAP;
              cause_d = CAUSE_TIMEOUT;
            end
          end
          3'd3: step_d = 3'd4;
          default: begin
            phase_d = PH_EXEC;
            step_d  = 3'd1;
          end
        endcase
      end
      PH_EXEC: begin
        phase_d = PH_FETCH;
        step_d  = 3'd1;
        case (op)
          OP_CLEAR, OP_INC1, OP_DEC1: begin
            if (step_q == 3'd1) begin
              phase_d = PH_EXEC;
              step_d  = 3'd2;
            end
          end
          OP_ADD: begin
            if (step_q == 3'd4) begin
              phase_d = PH_EXEC;
              if (bus.mem_ready) begin
                step_d = 3'd5;
              end else if (expire) begin
                phase_d = PH_TRAP;
                cause_d = CAUSE_TIMEOUT;
              end else begin
                step_d = step_q;
              end
            end else if (step_q < 3'd4) begin
              phase_d = PH_EXEC;
              step_d  = step_q + 3'd1;
            end
          end
          OP_LOAD, OP_STORE: begin
            if (step_q == 3'd1) begin
              phase_d = PH_EXEC;
              step_d  = 3'd2;
            end else if (!bus.mem_ready) begin
              if (expire) begin
                phase_d = PH_TRAP;
                cause_d = CAUSE_TIMEOUT;
              end else begin
                phase_d = PH_EXEC;
                step_d  = step_q;
              end
            end
          end
          OP_JUMP, OP_BUZ, OP_NOP: begin
          end
          OP_HALT: begin
            phase_d = PH_HALT;
          end
          default: begin
            phase_d = PH_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      PH_HALT: begin
        if (bus.run) begin
          phase_d = PH_FETCH;
          step_d  = 3'd1;
        end
      end
      PH_TRAP: begin
      end
    endcase
  end

  // Output decode. Everything starts inactive with func=CLR; each step
  // raises only its own enables, so at most one bus driver is ever on.
  // HALT and TRAP fall through with all enables off.
  always_comb begin
    oeMs     = 1'b0;
    oeIr     = 1'b0;
    oePc     = 1'b0;
    oeAlu    = 1'b0;
    oeD      = '0;
    func     = FUNC_CLR;
    rdStrobe = 1'b0;
    wrStrobe = 1'b0;
    weMar    = 1'b0;
    weIr     = 1'b0;
    wePc     = 1'b0;
    weAlu    = 1'b0;
    weD      = '0;
    if (phase_q == PH_FETCH) begin
      case (step_q)
        3'd1: begin
          oePc  = 1'b1;
          weMar = 1'b1;
        end
        3'd2: begin
          rdStrobe = 1'b1;
          oeMs     = bus.mem_ready;
          weIr     = bus.mem_ready;
        end
        3'd3: begin
          oePc  = 1'b1;
          func  = FUNC_INC;
          weAlu = 1'b1;
        end
        3'd4: begin
          oeAlu = 1'b1;
          wePc  = 1'b1;
        end
        default: begin
        end
      endcase
    end else if (phase_q == PH_EXEC) begin
      case (op)
        OP_CLEAR, OP_INC1, OP_DEC1: begin
          if (step_q == 3'd1) begin
            weAlu = 1'b1;
            if (op != OP_CLEAR) begin
              oeD  = dSel;
              func = (op == OP_INC1) ? FUNC_INC : FUNC_DEC;
            end
          end else begin
            oeAlu = 1'b1;
            weD   = dSel;
          end
        end
        OP_ADD: begin
          case (step_q)
            3'd1: weAlu = 1'b1;
            3'd2: begin
              oeD   = dSel;
              func  = FUNC_ADD;
              weAlu = 1'b1;
            end
            3'd3: begin
              oeIr  = 1'b1;
              weMar = 1'b1;
            end
            3'd4: begin
              rdStrobe = 1'b1;
              oeMs     = bus.mem_ready;
              weAlu    = bus.mem_ready;
              func     = bus.mem_ready ? FUNC_ADD : FUNC_CLR;
            end
            default: begin
              oeAlu = 1'b1;
              weD   = dSel;
            end
          endcase
        end
        OP_JUMP: begin
          oeIr = 1'b1;
          wePc = 1'b1;
        end
        OP_BUZ: begin
          oeIr = bus.zero;
          wePc = bus.zero;
        end
        OP_LOAD: begin
          if (step_q == 3'd1) begin
            oeIr  = 1'b1;
            weMar = 1'b1;
          end else begin
            rdStrobe = 1'b1;
            oeMs     = bus.mem_ready;
            weD      = bus.mem_ready ? dSel : '0;
          end
        end
        OP_STORE: begin
          if (step_q == 3'd1) begin
            oeIr  = 1'b1;
            weMar = 1'b1;
          end else begin
            oeD      = dSel;
            wrStrobe = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.oe_ms      = oeMs;
  assign bus.oe_ir      = oeIr;
  assign bus.oe_pc      = oePc;
  assign bus.oe_alureg  = oeAlu;
  assign bus.oe_d       = oeD;
  assign bus.func       = func;
  assign bus.read       = rdStrobe;
  assign bus.write      = wrStrobe;
  assign bus.we_mar     = weMar;
  assign bus.we_ir      = weIr;
  assign bus.we_pc      = wePc;
  assign bus.we_alureg  = weAlu;
  assign bus.we_d       = weD;
  assign bus.fetching   = (phase_q == PH_FETCH);
  assign bus.halted     = (phase_q == PH_HALT);
  assign bus.trap       = (phase_q == PH_TRAP);
  assign bus.trap_cause = cause_q;

endmodule

// File: tb/tb_cu_gen2.sv
// tb_cu_gen2
// Directed bench for cu_gen2 (OPCODE_W=4, NUM_DREGS=4, MEM_TIMEOUT=16).
// Every output is packed into one struct per cycle and compared against a
// hand-written expectation for that micro-step.
module tb_cu_gen2;

  typedef struct packed {
    logic       oeMs;
    logic       oeIr;
    logic       oePc;
    logic       oeAlu;
    logic [3:0] oeD;
    logic [1:0] func;
    logic       rd;
    logic       wr;
    logic       weMar;
    logic       weIr;
    logic       wePc;
    logic       weAlu;
    logic [3:0] weD;
    logic       fetching;
    logic       halted;
    logic       trap;
    logic [1:0] cause;
  } ctl_t;

  logic clk = 1'b0;
  logic rst;
  int   checkCount = 0;
  int   passCount  = 0;

  always #5 clk = ~clk;

  cu_gen2_if #(.OPCODE_W(4), .NUM_DREGS(4)) bus();

  cu_gen2 #(
    .OPCODE_W   (4),
    .NUM_DREGS  (4),
    .MEM_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Snapshot of every CU output in the struct layout.
  function automatic ctl_t observe();
    ctl_t c;
    c.oeMs     = bus.oe_ms;
    c.oeIr     = bus.oe_ir;
    c.oePc     = bus.oe_pc;
    c.oeAlu    = bus.oe_alureg;
    c.oeD      = bus.oe_d;
    c.func     = bus.func;
    c.rd       = bus.read;
    c.wr       = bus.write;
    c.weMar    = bus.we_mar;
    c.weIr     = bus.we_ir;
    c.wePc     = bus.we_pc;
    c.weAlu    = bus.we_alureg;
    c.weD      = bus.we_d;
    c.fetching = bus.fetching;
    c.halted   = bus.halted;
    c.trap     = bus.trap;
    c.cause    = bus.trap_cause;
    return c;
  endfunction

  function automatic ctl_t expF1();
    ctl_t e;
    e          = '0;
    e.oePc     = 1'b1;
    e.weMar    = 1'b1;
    e.fetching = 1'b1;
    return e;
  endfunction

  // Advance to just after the next rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Hard stop if the sequence ever desynchronises badly.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset();
    ctl_t e;
    rst           = 1'b0;
    bus.opcode    = '0;
    bus.reg_sel   = '0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    bus.run       = 1'b0;
    nextCycle();
    nextCycle();
    rst = 1'b1;
    #1;
    e = expF1();
    checkCount++;
    if (observe() !== e) $display("[TB] FAIL reset_f1: got %h want %h", observe(), e);
    else passCount++;
  endtask

  // Runs F1..F4 with `waits` cycles of mem_ready low in F2; ends right
  // after the edge into E1.
  task automatic doFetch(input int waits, input string tag);
    ctl_t e;
    bus.mem_ready = 1'b1;
    #1;
    e = expF1();
    checkCount++;
    if (observe() !== e) $display("[TB] FAIL %s_f1: got %h want %h", tag, observe(), e);
    else passCount++;
    nextCycle();
    for (int w = 0; w <= waits; w++) begin
      bus.mem_ready = (w == waits);
      #1;
      e          = '0;
      e.rd       = 1'b1;
      e.fetching = 1'b1;
      e.oeMs     = (w == waits);
      e.weIr     = (w == waits);
      checkCount++;
      if (observe() !== e) $display("[TB] FAIL %s_f2_w%0d: got %h want %h", tag, w, observe(), e);
      else passCount++;
      nextCycle();
    end
    #1;
    e = '0; e.oePc = 1'b1; e.func = 2'd1; e.weAlu = 1'b1; e.fetching = 1'b1;
    checkCount++;
    if (observe() !== e) $display("[TB] FAIL %s_f3: got %h want %h", tag, observe(), e);
    else passCount++;
    nextCycle();
    #1;
    e = '0; e.oeAlu = 1'b1; e.wePc = 1'b1; e.fetching = 1'b1;
    checkCount++;
    if (observe() !== e) $display("[TB] FAIL %s_f4: got %h want %h", tag, observe(), e);
    else passCount++;
    nextCycle();
  endtask

  task automatic test_inc1();
    ctl_t e;
    bus.opcode  = 4'd1;
    bus.reg_sel = 2'd2;
    doFetch(0, "inc1");
    #1;
    e = '0; e.oeD = 4'b0100; e.func = 2'd1; e.weAlu = 1'b1;
    checkCount++;
    if (observe() !== e) $display("[TB] FAIL inc1_e1: got %h want %h", observe(), e);
    else passCount++;
    nextCycle();
    #1;
    e = '0; e.oeAlu = 1'b1; e.weD = 4'b0100;
    checkCount++;
    if (observe() !== e) $display("[TB] FAIL inc1_e2: got %h want %h", observe(), e);
    else passCount++;
    nextCycle();
    #1;
    e = expF1();
    checkCount++;
    if (observe() !== e) $display("[TB] FAIL inc1_next_f1: got %h want %h", observe(), e);
    else passCount++;
  endtask

  task automatic test_load();
    ctl_t e;
    bus.opcode  = 4'd6;
    bus.reg_sel = 2'd1;
    doFetch(3, "load");
    #1;
    e = '0; e.oeIr = 1'b1; e.weMar = 1'b1;
    checkCount++;
    if (observe() !== e) $display("[TB] FAIL load_e1: got %h want %h", observe(), e);
    else passCount++;
    nextCycle();
    for (int w = 0; w <= 2; w++) begin
      bus.mem_ready = (w == 2);
      #1;
      e      = '0;
      e.rd   = 1'b1;
      e.oeMs = (w == 2);
      e.weD  = (w == 2) ? 4'b0010 : 4'b0000;
      checkCount++;
      if (observe() !== e) $display("[TB] FAIL load_e2_w%0d: got %h want %h", w, observe(), e);
      else passCount++;
      nextCycle();
    end
    bus.mem_ready = 1'b1;
    #1;
    e = expF1();
    checkCount++;
    if (observe() !== e) $display("[TB] FAIL load_next_f1: got %h want %h", observe(), e);
    else passCount++;
  endtask

  task automatic test_buz();
    ctl_t e;
    for (int z = 1; z >= 0; z--) begin
      bus.opcode = 4'd5;
      bus.zero   = (z == 1);
      doFetch(0, "buz");
      #1;
      e      = '0;
      e.oeIr = (z == 1);
      e.wePc = (z == 1);
      checkCount++;
      if (observe() !== e) $display("[TB] FAIL buz_e1_z%0d: got %h want %h", z, observe(), e);
      else passCount++;
      nextCycle();
      #1;
      e = expF1();
      checkCount++;
      if (observe() !== e) $display("[TB] FAIL buz_next_f1_z%0d: got %h want %h", z, observe(), e);
      else passCount++;
    end
    bus.zero = 1'b0;
  endtask

  task automatic test_add();
    ctl_t e;
    ctl_t exp[6];
    bus.opcode  = 4'd2;
    bus.reg_sel = 2'd3;
    exp[0] = '0; exp[0].weAlu = 1'b1;
    exp[1] = '0; exp[1].oeD = 4'b1000; exp[1].func = 2'd3; exp[1].weAlu = 1'b1;
    exp[2] = '0; exp[2].oeIr = 1'b1; exp[2].weMar = 1'b1;
    exp[3] = '0; exp[3].rd = 1'b1;
    exp[4] = '0; exp[4].rd = 1'b1; exp[4].oeMs = 1'b1; exp[4].func = 2'd3; exp[4].weAlu = 1'b1;
    exp[5] = '0; exp[5].oeAlu = 1'b1; exp[5].weD = 4'b1000;
    doFetch(0, "add");
    for (int s = 0; s < 6; s++) begin
      bus.mem_ready = (s != 3);
      #1;
      checkCount++;
      if (observe() !== exp[s]) $display("[TB] FAIL add_step%0d: got %h want %h", s, observe(), exp[s]);
      else passCount++;
      nextCycle();
    end
    #1;
    e = expF1();
    checkCount++;
    if (observe() !== e) $display("[TB] FAIL add_next_f1: got %h want %h", observe(), e);
    else passCount++;
  endtask

  task automatic test_back_to_back();
    ctl_t e;
    bus.opcode = 4'd4;
    doFetch(0, "jump");
    #1;
    e = '0; e.oeIr = 1'b1; e.wePc = 1'b1;
    checkCount++;
    if (observe() !== e) $display("[TB] FAIL jump_e1: got %h want %h", observe(), e);
    else passCount++;
    nextCycle();
    bus.opcode = 4'd8;
    doFetch(0, "nop");
    #1;
    e = '0;
    checkCount++;
    if (observe() !== e) $display("[TB] FAIL nop_e1: got %h want %h", observe(), e);
    else passCount++;
    nextCycle();
    bus.opcode  = 4'd0;
    bus.reg_sel = 2'd0;
    doFetch(0, "clear");
    #1;
    e = '0; e.weAlu = 1'b1;
    checkCount++;
    if (observe() !== e) $display("[TB] FAIL clear_e1: got %h want %h", observe(), e);
    else passCount++;
    nextCycle();
    #1;
    e = '0; e.oeAlu = 1'b1; e.weD = 4'b0001;
    checkCount++;
    if (observe() !== e) $display("[TB] FAIL clear_e2: got %h want %h", observe(), e);
    else passCount++;
    nextCycle();
    bus.opcode  = 4'd3;
    bus.reg_sel = 2'd1;
    doFetch(0, "dec1");
    #1;
    e = '0; e.oeD = 4'b0010; e.func = 2'd2; e.weAlu = 1'b1;
    checkCount++;
    if (observe() !== e) $display("[TB] FAIL dec1_e1: got %h want %h", observe(), e);
    else passCount++;
    nextCycle();
    #1;
    e = '0; e.oeAlu = 1'b1; e.weD = 4'b0010;
    checkCount++;
    if (observe() !== e) $display("[TB] FAIL dec1_e2: got %h want %h", observe(), e);
    else passCount++;
    nextCycle();
  endtask

  task automatic test_halt();
    ctl_t e;
    bus.opcode = 4'd9;
    bus.run    = 1'b0;
    doFetch(0, "halt");
    #1;
    e = '0;
    checkCount++;
    if (observe() !== e) $display("[TB] FAIL halt_e1: got %h want %h", observe(), e);
    else passCount++;
    nextCycle();
    for (int c = 0; c < 5; c++) begin
      #1;
      e = '0; e.halted = 1'b1;
      checkCount++;
      if (observe() !== e) $display("[TB] FAIL halt_hold%0d: got %h want %h", c, observe(), e);
      else passCount++;
      nextCycle();
    end
    bus.run = 1'b1;
    #1;
    e = '0; e.halted = 1'b1;
    checkCount++;
    if (observe() !== e) $display("[TB] FAIL halt_run_cycle: got %h want %h", observe(), e);
    else passCount++;
    nextCycle();
    bus.run = 1'b0;
    #1;
    e = expF1();
    checkCount++;
    if (observe() !== e) $display("[TB] FAIL halt_resume_f1: got %h want %h", observe(), e);
    else passCount++;
  endtask

  task automatic test_reset_mid_add();
    ctl_t e;
    bus.opcode  = 4'd2;
    bus.reg_sel = 2'd0;
    doFetch(0, "abort");
    nextCycle();
    nextCycle();
    nextCycle();
    bus.mem_ready = 1'b0;
    #1;
    e = '0; e.rd = 1'b1;
    checkCount++;
    if (observe() !== e) $display("[TB] FAIL abort_e4: got %h want %h", observe(), e);
    else passCount++;
    rst = 1'b0;
    nextCycle();
    #1;
    e = expF1();
    checkCount++;
    if (observe() !== e) $display("[TB] FAIL abort_f1: got %h want %h", observe(), e);
    else passCount++;
    rst           = 1'b1;
    bus.mem_ready = 1'b1;
  endtask

  task automatic test_illegal();
    ctl_t e;
    bus.opcode = 4'd12;
    doFetch(0, "illegal");
    #1;
    e = '0;
    checkCount++;
    if (observe() !== e) $display("[TB] FAIL illegal_e1: got %h want %h", observe(), e);
    else passCount++;
    nextCycle();
    bus.run = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      e = '0; e.trap = 1'b1; e.cause = 2'd1;
      checkCount++;
      if (observe() !== e) $display("[TB] FAIL illegal_trap%0d: got %h want %h", c, observe(), e);
      else passCount++;
      nextCycle();
    end
    bus.run = 1'b0;
    rst     = 1'b0;
    nextCycle();
    rst = 1'b1;
    #1;
    e = expF1();
    checkCount++;
    if (observe() !== e) $display("[TB] FAIL illegal_reset_f1: got %h want %h", observe(), e);
    else passCount++;
  endtask

  task automatic test_timeout();
    ctl_t e;
    bus.opcode  = 4'd7;
    bus.reg_sel = 2'd0;
    doFetch(0, "store");
    #1;
    e = '0; e.oeIr = 1'b1; e.weMar = 1'b1;
    checkCount++;
    if (observe() !== e) $display("[TB] FAIL store_e1: got %h want %h", observe(), e);
    else passCount++;
    nextCycle();
    bus.mem_ready = 1'b0;
    for (int c = 0; c < 16; c++) begin
      #1;
      e = '0; e.oeD = 4'b0001; e.wr = 1'b1;
      checkCount++;
      if (observe() !== e) $display("[TB] FAIL store_wait%0d: got %h want %h", c, observe(), e);
      else passCount++;
      nextCycle();
    end
    for (int c = 0; c < 3; c++) begin
      #1;
      e = '0; e.trap = 1'b1; e.cause = 2'd2;
      checkCount++;
      if (observe() !== e) $display("[TB] FAIL store_trap%0d: got %h want %h", c, observe(), e);
      else passCount++;
      nextCycle();
    end
    rst = 1'b0;
    nextCycle();
    rst           = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    e = expF1();
    checkCount++;
    if (observe() !== e) $display("[TB] FAIL store_reset_f1: got %h want %h", observe(), e);
    else passCount++;
  endtask

  initial begin
    test_reset();
    test_inc1();
    test_load();
    test_buz();
    test_add();
    test_back_to_back();
    test_halt();
    test_reset_mid_add();
    test_illegal();
    test_timeout();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
